// File: rtl/dmem_responder.sv
// Load/store memory responder: accepts one request per handshake, waits a fixed
// latency, then performs a lane-merged store or an extended load on a word array.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wen_q, wen_d;
  logic [31:0]        addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               valid_q, valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic [31:0]        offset;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         lane;
  logic               access_err;
  logic [31:0]        rd_word;
  logic [31:0]        shifted;
  logic [31:0]        load_data;
  logic [3:0]         wmask;
  logic [31:0]        wword;
  logic [31:0]        merged;
  logic               mem_we;

  // Address decode and fault detection on the latched request
  always_comb begin
    offset     = addr_q - BASE_ADDR;
    idx        = offset[IDX_W+1:2];
    lane       = offset[1:0];
    access_err = (offset[31:IDX_W+2] != '0) ||
                 (size_q == 2'b11) ||
                 (size_q == 2'b01 && lane[0]) ||
                 (size_q == 2'b10 && lane != 2'b00);
  end

  // Load lane extraction and extension
  always_comb begin
    rd_word = mem_q[idx];
    shifted = rd_word >> {lane, 3'b000};
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Store byte-lane merge into the current word
  always_comb begin
    case (size_q)
      2'b00: begin
        wmask = 4'(4'b0001 << lane);
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask = 4'(4'b0011 << lane);
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wword = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = wmask[i] ? wword[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  assign mem_we = (state_q == S_WAIT) && (count_q == '0) && wen_q && !access_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= merged;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          count_d = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q == '0) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          err_d   = access_err;
          rdata_d = (wen_q || access_err) ? 32'h0 : load_data;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wen_q   <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Ready must read low for the whole reset pulse, not just after the next edge
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
